pipeline_trace_recorder: RTL and testbench

- Synthesizable, parametrised pipeline trace recorder. Records per-stage AXIS handshake activity into an on-chip circular buffer, with a tag-match trigger and a post-trigger capture window.
- Sits beside the core and taps the valid/ready/tag of each inter-stage stream. Software or the testbench reads the frozen trace through a random-access read port.
- Generalises the text logger to N stages, configurable depth and timestamp width, and hardware triggering.

---
 rtl/pipeline_trace_recorder_pkg.sv | 27 ++
 rtl/pipeline_trace_recorder_if.sv | 12 +
 rtl/pipeline_trace_recorder_trace_ram.sv | 33 +++
 rtl/pipeline_trace_recorder.sv | 156 +++++++++++++++
 tb/tb_pipeline_trace_recorder.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_trace_recorder_pkg.sv
// Shared types and default widths for the pipeline trace recorder.
// PIPELINE_TRACE_STALL_EN adds a stall_mask field to trace_entry_t.
package pipeline_trace_pkg;

  localparam int unsigned DEF_NUM_STAGES = 5;
  localparam int unsigned DEF_TAG_WIDTH  = 32;
  localparam int unsigned DEF_DEPTH      = 256;
  localparam int unsigned DEF_TS_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

  // Decoded entry layout at the default widths
  typedef struct packed {
    logic [DEF_TS_WIDTH-1:0]   ts;
    logic [DEF_NUM_STAGES-1:0] fire_mask;
`ifdef PIPELINE_TRACE_STALL_EN
    logic [DEF_NUM_STAGES-1:0] stall_mask;
`endif
    logic [DEF_TAG_WIDTH-1:0]  tag;
  } trace_entry_t;

endpackage

// File: rtl/pipeline_trace_recorder_if.sv
// Per-stage AXIS handshake taps (valid/ready/tag) observed by the trace recorder.
interface pipeline_trace_recorder_if #(
  parameter int unsigned NUM_STAGES = pipeline_trace_pkg::DEF_NUM_STAGES,
  parameter int unsigned TAG_WIDTH  = pipeline_trace_pkg::DEF_TAG_WIDTH
);
  logic [NUM_STAGES-1:0]           stage_valid;
  logic [NUM_STAGES-1:0]           stage_ready;
  logic [NUM_STAGES*TAG_WIDTH-1:0] stage_tag;

  modport master (output stage_valid, stage_ready, stage_tag);
  modport slave  (input  stage_valid, stage_ready, stage_tag);
endinterface

// File: rtl/pipeline_trace_recorder_trace_ram.sv
// Simple dual-port trace buffer: one write port, one registered read port.
module trace_ram #(
  parameter  int unsigned DEPTH   = 256,
  parameter  int unsigned ENTRY_W = 53,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register carries the reset; array contents do not
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_o <= '0;
    end else begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/pipeline_trace_recorder.sv
// Records per-stage handshake activity into a circular trace with tag trigger and
// post-trigger window. Define PIPELINE_TRACE_STALL_EN to also record stall cycles.
module pipeline_trace_recorder
  import pipeline_trace_pkg::*;
#(
  parameter  int unsigned NUM_STAGES = DEF_NUM_STAGES,
  parameter  int unsigned TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter  int unsigned DEPTH      = DEF_DEPTH,
  parameter  int unsigned TS_WIDTH   = DEF_TS_WIDTH,
  localparam int unsigned ADDR_W     = $clog2(DEPTH),
  localparam int unsigned SEL_W      = $clog2(NUM_STAGES),
`ifdef PIPELINE_TRACE_STALL_EN
  localparam int unsigned ENTRY_W    = TS_WIDTH + 2*NUM_STAGES + TAG_WIDTH
`else
  localparam int unsigned ENTRY_W    = TS_WIDTH + NUM_STAGES + TAG_WIDTH
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  pipeline_trace_recorder_if.slave tap,
  input  logic [SEL_W-1:0]        trig_stage,
  input  logic [TAG_WIDTH-1:0]    trig_tag,
  input  logic [ADDR_W:0]         post_count,
  output logic [1:0]              state_o,
  output logic [ADDR_W:0]         entry_count,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [ENTRY_W-1:0]      rd_data,
  output logic                    rd_valid
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  trace_state_t          state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [ADDR_W:0]       remaining_q, remaining_d;
  logic [TS_WIDTH-1:0]   ts_q;
  logic                  rd_valid_q, rd_valid_d;

  logic [NUM_STAGES-1:0] fire;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic                  trig_hit;
  logic                  event_c;
  logic                  wr_en;
  logic [ENTRY_W-1:0]    wr_data;
  logic [ADDR_W-1:0]     rd_phys;

  assign fire = tap.stage_valid & tap.stage_ready;

`ifdef PIPELINE_TRACE_STALL_EN
  logic [NUM_STAGES-1:0] stall;
  assign stall   = tap.stage_valid & ~tap.stage_ready;
  assign event_c = (|fire) | (&ts_q) | (|stall);
  assign wr_data = {ts_q, fire, stall, sel_tag};
`else
  assign event_c = (|fire) | (&ts_q);
  assign wr_data = {ts_q, fire, sel_tag};
`endif

  // Tag of the highest-indexed firing stage, and trigger match on the watched stage
  always_comb begin
    sel_tag  = '0;
    trig_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (fire[i]) begin
        sel_tag = tap.stage_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
      if ((SEL_W'(i) == trig_stage) && fire[i] &&
          (tap.stage_tag[i*TAG_WIDTH +: TAG_WIDTH] == trig_tag)) begin
        trig_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    wr_en       = 1'b0;
    if (arm) begin
      state_d  = ARMED;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        ARMED: begin
          wr_en = event_c;
          if (event_c && trig_hit) begin
            if (post_count == '0) begin
              state_d = DONE;
            end else begin
              remaining_d = post_count;
              state_d     = POST;
            end
          end
        end
        POST: begin
          wr_en = event_c;
          if (event_c) begin
            remaining_d = remaining_q - (ADDR_W+1)'(1);
            if (remaining_q == (ADDR_W+1)'(1)) begin
              state_d = DONE;
            end
          end
        end
        default: ;
      endcase
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        count_d  = (count_q == FULL) ? count_q : count_q + (ADDR_W+1)'(1);
      end
    end
  end

  // Once the buffer has wrapped, the oldest entry sits at the write pointer
  assign rd_phys    = ((count_q == FULL) ? wr_ptr_q : '0) + rd_addr;
  assign rd_valid_d = (state_q == DONE) && ({1'b0, rd_addr} < count_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      ts_q        <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      ts_q        <= ts_q + TS_WIDTH'(1);
      rd_valid_q  <= rd_valid_d;
    end
  end

  trace_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_phys),
    .rdata_o (rd_data)
  );

  assign state_o     = state_q;
  assign entry_count = count_q;
  assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_pipeline_trace_recorder.sv
// Bench for pipeline_trace_recorder (DEPTH=8, TS_WIDTH=4) against a queue-based trace model.
module tb_pipeline_trace_recorder;

  localparam int unsigned NS  = 5;
  localparam int unsigned TW  = 32;
  localparam int unsigned DP  = 8;
  localparam int unsigned TSW = 4;
  localparam int unsigned AW  = 3;
  localparam int unsigned SW  = 3;
`ifdef PIPELINE_TRACE_STALL_EN
  localparam int unsigned STW = NS;
`else
  localparam int unsigned STW = 0;
`endif
  localparam int unsigned EW       = TSW + NS + STW + TW;
  localparam int unsigned FIRE_LSB = TW + STW;

  logic           clk = 1'b0;
  logic           rst;
  logic           arm;
  logic [SW-1:0]  trig_stage;
  logic [TW-1:0]  trig_tag;
  logic [AW:0]    post_count;
  logic [1:0]     state_o;
  logic [AW:0]    entry_count;
  logic [AW-1:0]  rd_addr;
  logic [EW-1:0]  rd_data;
  logic           rd_valid;

  pipeline_trace_recorder_if #(.NUM_STAGES(NS), .TAG_WIDTH(TW)) tap ();

  pipeline_trace_recorder #(
    .NUM_STAGES (NS),
    .TAG_WIDTH  (TW),
    .DEPTH      (DP),
    .TS_WIDTH   (TSW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .tap         (tap),
    .trig_stage  (trig_stage),
    .trig_tag    (trig_tag),
    .post_count  (post_count),
    .state_o     (state_o),
    .entry_count (entry_count),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: trace as a list of logical entries, oldest first
  bit            m_ok    = 1'b0;
  int            m_state = 0;
  int            m_ts    = 0;
  int            m_rem   = 0;
  logic [EW-1:0] m_q[$];

  task automatic set_tap(input logic [NS-1:0] v, input logic [NS-1:0] r);
    tap.stage_valid = v;
    tap.stage_ready = r;
  endtask

  task automatic set_tag(input int i, input logic [TW-1:0] val);
    tap.stage_tag[i*TW +: TW] = val;
  endtask

  // One clock: predict from current inputs, advance, compare every observable
  task automatic cycle();
    logic [NS-1:0] f;
    logic [NS-1:0] s;
    logic [TW-1:0] t;
    logic [EW-1:0] e;
    logic          ev;
    logic          hit;
    logic          exp_rv;
    logic          did_rst;
    logic [EW-1:0] exp_rd;
    int            ts_i;
    f  = tap.stage_valid & tap.stage_ready;
    s  = tap.stage_valid & ~tap.stage_ready;
    t  = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (f[i]) begin
        t = tap.stage_tag[i*TW +: TW];
        break;
      end
    end
    ts_i = int'(trig_stage);
    hit  = (ts_i < NS) && f[ts_i] && (tap.stage_tag[ts_i*TW +: TW] == trig_tag);
`ifdef PIPELINE_TRACE_STALL_EN
    ev = (f != '0) || (m_ts == 15) || (s != '0);
`else
    ev = (f != '0) || (m_ts == 15);
`endif
    exp_rv = m_ok && (m_state == 3) && (int'(rd_addr) < m_q.size());
    exp_rd = '0;
    if (exp_rv) exp_rd = m_q[rd_addr];
    did_rst = !rst;
    @(posedge clk);
    cyc++;
    if (did_rst) begin
      m_ok = 1'b1; m_state = 0; m_ts = 0; m_rem = 0; exp_rv = 1'b0;
      m_q.delete();
    end else begin
      if (arm) begin
        m_state = 1;
        m_q.delete();
      end else if ((m_state == 1 || m_state == 2) && ev) begin
`ifdef PIPELINE_TRACE_STALL_EN
        e = {4'(m_ts), f, s, t};
`else
        e = {4'(m_ts), f, t};
`endif
        m_q.push_back(e);
        if (m_q.size() > DP) void'(m_q.pop_front());
        if (m_state == 1) begin
          if (hit) begin
            if (post_count == '0) m_state = 3;
            else begin m_rem = int'(post_count); m_state = 2; end
          end
        end else begin
          m_rem--;
          if (m_rem == 0) m_state = 3;
        end
      end
      m_ts = (m_ts + 1) % 16;
    end
    #1;
    if (m_ok) begin
      n_checks++;
      if (state_o !== 2'(m_state)) $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, state_o, m_state);
      else n_pass++;
      n_checks++;
      if (entry_count !== 4'(m_q.size())) $display("FAIL entry_count cyc=%0d got=%0d exp=%0d", cyc, entry_count, m_q.size());
      else n_pass++;
      n_checks++;
      if (rd_valid !== exp_rv) $display("FAIL rd_valid cyc=%0d got=%b exp=%b", cyc, rd_valid, exp_rv);
      else n_pass++;
      if (exp_rv) begin
        n_checks++;
        if (rd_data !== exp_rd) $display("FAIL rd_data cyc=%0d got=%h exp=%h", cyc, rd_data, exp_rd);
        else n_pass++;
      end
      if (did_rst) begin
        n_checks++;
        if (rd_data !== '0) $display("FAIL rd_data_reset cyc=%0d got=%h exp=0", cyc, rd_data);
        else n_pass++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; arm = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_tap(5'($urandom), 5'($urandom));
      tap.stage_tag = {5{32'($urandom)}};
      cycle();
    end
    rst = 1'b1; arm = 1'b0; set_tap('0, '0);
    for (int k = 0; k < 10; k++) cycle();
    n_checks++;
    if (state_o !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state_o); else n_pass++;
    n_checks++;
    if (entry_count !== '0) $display("FAIL reset_count got=%0d exp=0", entry_count); else n_pass++;
    n_checks++;
    if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); else n_pass++;
  endtask

  task automatic test_basic_trigger();
    trig_stage = 3'd2; trig_tag = 32'h104; post_count = 4'd1; rd_addr = '0;
    set_tap('0, '0);
    arm = 1'b1; cycle(); arm = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_tag(2, 32'(32'h100 + 4*k));
      set_tap(5'b00100, 5'b10101);
      cycle();
    end
    set_tap('0, '0);
    n_checks++;
    if (state_o !== 2'd3) $display("FAIL basic_state got=%0d exp=3", state_o); else n_pass++;
    n_checks++;
    if (entry_count !== 4'd3) $display("FAIL basic_count got=%0d exp=3", entry_count); else n_pass++;
    for (int a = 0; a < 3; a++) begin
      rd_addr = 3'(a);
      cycle();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data[TW-1:0] !== 32'(32'h100 + 4*a))
        $display("FAIL basic_tag addr=%0d got=%h valid=%b exp=%h", a, rd_data[TW-1:0], rd_valid, 32'h100 + 4*a);
      else n_pass++;
      n_checks++;
      if (rd_data[FIRE_LSB +: NS] !== 5'b00100)
        $display("FAIL basic_fire addr=%0d got=%b exp=00100", a, rd_data[FIRE_LSB +: NS]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    trig_stage = 3'd0; trig_tag = 32'd20; post_count = 4'd0;
    arm = 1'b1; cycle(); arm = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      set_tag(0, 32'(k));
      set_tap(5'b00001, 5'b00001);
      cycle();
    end
    set_tap('0, '0);
    n_checks++;
    if (state_o !== 2'd3) $display("FAIL wrap_state got=%0d exp=3", state_o); else n_pass++;
    n_checks++;
    if (entry_count !== 4'd8) $display("FAIL wrap_count got=%0d exp=8", entry_count); else n_pass++;
    rd_addr = 3'd0; cycle();
    n_checks++;
    if (rd_data[TW-1:0] !== 32'd13) $display("FAIL wrap_oldest got=%0d exp=13", rd_data[TW-1:0]); else n_pass++;
    rd_addr = 3'd7; cycle();
    n_checks++;
    if (rd_data[TW-1:0] !== 32'd20) $display("FAIL wrap_newest got=%0d exp=20", rd_data[TW-1:0]); else n_pass++;
  endtask

  task automatic test_marker();
    set_tap('0, '0);
    trig_stage = 3'd3; trig_tag = 32'hABC; post_count = 4'd0;
    for (int g = 0; g < 20 && m_ts != 15; g++) cycle();
    arm = 1'b1; cycle(); arm = 1'b0;
    for (int k = 0; k < 40; k++) cycle();
    set_tag(3, 32'hABC);
    set_tap(5'b01000, 5'b01000);
    cycle();
    set_tap('0, '0);
    n_checks++;
    if (entry_count !== 4'd3) $display("FAIL marker_count got=%0d exp=3", entry_count); else n_pass++;
    for (int a = 0; a < 2; a++) begin
      rd_addr = 3'(a); cycle();
      n_checks++;
      if (rd_data[FIRE_LSB +: NS] !== '0 || rd_data[EW-1 -: TSW] !== 4'hF || rd_data[TW-1:0] !== '0)
        $display("FAIL marker_entry addr=%0d got=%h exp ts=f fire=0 tag=0", a, rd_data);
      else n_pass++;
    end
    rd_addr = 3'd2; cycle();
    n_checks++;
    if (rd_data[FIRE_LSB +: NS] !== 5'b01000 || rd_data[TW-1:0] !== 32'hABC)
      $display("FAIL marker_trigger got=%h exp fire=01000 tag=abc", rd_data);
    else n_pass++;
  endtask

  task automatic test_rearm();
    trig_stage = 3'd1; trig_tag = 32'h55; post_count = 4'd10;
    arm = 1'b1; cycle(); arm = 1'b0;
    set_tag(1, 32'h55); set_tap(5'b00010, 5'b00010); cycle();
    for (int k = 0; k < 3; k++) begin
      set_tag(1, 32'(32'h60 + k)); cycle();
    end
    n_checks++;
    if (state_o !== 2'd2) $display("FAIL rearm_post got=%0d exp=2", state_o); else n_pass++;
    set_tap('0, '0);
    arm = 1'b1; cycle(); arm = 1'b0;
    n_checks++;
    if (state_o !== 2'd1) $display("FAIL rearm_state got=%0d exp=1", state_o); else n_pass++;
    n_checks++;
    if (entry_count !== '0) $display("FAIL rearm_count got=%0d exp=0", entry_count); else n_pass++;
    rd_addr = 3'd0; cycle();
    n_checks++;
    if (rd_valid !== 1'b0) $display("FAIL rearm_rd_valid got=%b exp=0", rd_valid); else n_pass++;
  endtask

  task automatic test_stall();
    int exp_n;
    exp_n = (STW != 0) ? 3 : 1;
    set_tap('0, '0);
    trig_stage = 3'd1; trig_tag = 32'h77; post_count = 4'd0;
    for (int g = 0; g < 20 && m_ts != 0; g++) cycle();
    arm = 1'b1; cycle(); arm = 1'b0;
    set_tag(1, 32'h77);
    set_tap(5'b00010, 5'b00000); cycle(); cycle();
    set_tap(5'b00010, 5'b00010); cycle();
    set_tap('0, '0);
    n_checks++;
    if (state_o !== 2'd3) $display("FAIL stall_state got=%0d exp=3", state_o); else n_pass++;
    n_checks++;
    if (entry_count !== 4'(exp_n)) $display("FAIL stall_count got=%0d exp=%0d", entry_count, exp_n); else n_pass++;
    rd_addr = 3'(exp_n - 1); cycle();
    n_checks++;
    if (rd_data[FIRE_LSB +: NS] !== 5'b00010 || rd_data[TW-1:0] !== 32'h77)
      $display("FAIL stall_fire_entry got=%h exp fire=00010 tag=77", rd_data);
    else n_pass++;
`ifdef PIPELINE_TRACE_STALL_EN
    for (int a = 0; a < 2; a++) begin
      rd_addr = 3'(a); cycle();
      n_checks++;
      if (rd_data[TW +: NS] !== 5'b00010 || rd_data[FIRE_LSB +: NS] !== '0)
        $display("FAIL stall_entry addr=%0d got=%h exp stall=00010 fire=0", a, rd_data);
      else n_pass++;
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom % 150) != 0;
      arm = ($urandom % 30) == 0;
      set_tap(5'($urandom & $urandom), 5'($urandom));
      for (int i = 0; i < NS; i++) set_tag(i, 32'(32'h10 * (1 + $urandom % 4)));
      if ($urandom % 8 == 0) begin
        trig_stage = 3'($urandom);
        trig_tag   = 32'(32'h10 * (1 + $urandom % 4));
        post_count = 4'($urandom);
      end
      rd_addr = 3'($urandom);
      cycle();
    end
    rst = 1'b1; arm = 1'b0; set_tap('0, '0);
  endtask

  initial begin
    rst = 1'b0; arm = 1'b0;
    trig_stage = '0; trig_tag = '0; post_count = '0; rd_addr = '0;
    tap.stage_valid = '0; tap.stage_ready = '0; tap.stage_tag = '0;
    @(negedge clk);
    test_reset();
    test_basic_trigger();
    test_wrap();
    test_marker();
    test_rearm();
    test_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
